// File: rtl/pmod_keypad_emulator.sv
// Responder side of a 4x4 Pmod keypad: presses one requested key for a timed
// sequence (optional bounce, hold, gap) and answers column scans with row patterns.
module pmod_keypad_emulator #(
  parameter int CNT_W         = 24,
  parameter int HOLD_CYCLES   = 5000000,
  parameter int GAP_CYCLES    = 1000000,
  parameter int BOUNCE_CYCLES = 100000,
  parameter int BOUNCE_PERIOD = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic       press_done,
  output logic [7:0] hit_count
);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_GAP} state_t;

  localparam logic [3:0] L1 = 4'b0111;
  localparam logic [3:0] L2 = 4'b1011;
  localparam logic [3:0] L3 = 4'b1101;
  localparam logic [3:0] L4 = 4'b1110;

  localparam logic             HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
  localparam logic             HAS_GAP     = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);

  // Returns {column pattern, row pattern} for a key code.
  function automatic logic [7:0] key_map(input logic [3:0] k);
    case (k)
      4'h1: return {L1, L1};
      4'h4: return {L1, L2};
      4'h7: return {L1, L3};
      4'h0: return {L1, L4};
      4'h2: return {L2, L1};
      4'h5: return {L2, L2};
      4'h8: return {L2, L3};
      4'hF: return {L2, L4};
      4'h3: return {L3, L1};
      4'h6: return {L3, L2};
      4'h9: return {L3, L3};
      4'hE: return {L3, L4};
      4'hA: return {L4, L1};
      4'hB: return {L4, L2};
      4'hC: return {L4, L3};
      default: return {L4, L4};
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             bphase_q, bphase_d;
  logic [3:0]       key_q;
  logic [3:0]       row_q, row_d;
  logic [7:0]       hit_q, hit_d;
  logic             hmatch_q, hmatch_d;
  logic             accept, pressed, match, done_c;
  logic [3:0]       kcol, krow;

  assign accept       = key_valid && (state_q == S_IDLE);
  assign {kcol, krow} = key_map(key_q);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bcnt_d   = bcnt_q;
    bphase_d = bphase_q;
    done_c   = 1'b0;
    pressed  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (accept) begin
          state_d  = HAS_BOUNCE ? S_BOUNCE : S_HOLD;
          bcnt_d   = '0;
          bphase_d = 1'b1;
        end
      end
      S_BOUNCE: begin
        pressed = bphase_q;
        if (bcnt_q == PERIOD_LAST) begin
          bcnt_d   = '0;
          bphase_d = ~bphase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
        if (timer_q == BOUNCE_LAST) begin
          state_d = S_HOLD;
          timer_d = '0;
        end
      end
      S_HOLD: begin
        pressed = 1'b1;
        if (timer_q == HOLD_LAST) begin
          done_c  = 1'b1;
          state_d = HAS_GAP ? S_GAP : S_IDLE;
          timer_d = '0;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only an exact single-low match on the key's column drives its row.
  always_comb begin
    match    = pressed && (Col == kcol);
    row_d    = match ? krow : 4'b1111;
    hmatch_d = match && (state_q == S_HOLD);
    hit_d    = hit_q;
    if (accept)
      hit_d = 8'd0;
    else if (hmatch_d && !hmatch_q)
      hit_d = sat_inc(hit_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
      row_q    <= 4'b1111;
      hit_q    <= 8'd0;
      hmatch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      row_q    <= row_d;
      hit_q    <= hit_d;
      hmatch_q <= hmatch_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) key_q <= key_code;
  end

  assign key_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign press_done = done_c;
  assign Row        = row_q;
  assign hit_count  = hit_q;

endmodule

// File: tb/tb_pmod_keypad_emulator.sv
// Scoreboard bench for pmod_keypad_emulator: two instances with short timings,
// one without bounce (A) and one with bounce and a long hold (B).
module tb_pmod_keypad_emulator;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] a_key, b_key, a_col, b_col;
  logic       a_valid, b_valid;
  logic       a_ready, a_busy, a_pd, b_ready, b_busy, b_pd;
  logic [3:0] a_row, b_row;
  logic [7:0] a_hit, b_hit;

  always #5 clock = ~clock;

  pmod_keypad_emulator #(
    .CNT_W(24), .HOLD_CYCLES(40), .GAP_CYCLES(10), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1)
  ) u_a (
    .clock(clock), .reset(reset), .key_code(a_key), .key_valid(a_valid),
    .key_ready(a_ready), .Col(a_col), .Row(a_row), .busy(a_busy),
    .press_done(a_pd), .hit_count(a_hit)
  );

  pmod_keypad_emulator #(
    .CNT_W(24), .HOLD_CYCLES(3000), .GAP_CYCLES(2), .BOUNCE_CYCLES(12), .BOUNCE_PERIOD(4)
  ) u_b (
    .clock(clock), .reset(reset), .key_code(b_key), .key_valid(b_valid),
    .key_ready(b_ready), .Col(b_col), .Row(b_row), .busy(b_busy),
    .press_done(b_pd), .hit_count(b_hit)
  );

  // Key map written out by hand: column and row pattern per key code.
  logic [3:0] key_col [16] = '{4'b0111, 4'b0111, 4'b1011, 4'b1101,
                               4'b0111, 4'b1011, 4'b1101, 4'b0111,
                               4'b1011, 4'b1101, 4'b1110, 4'b1110,
                               4'b1110, 4'b1110, 4'b1101, 4'b1011};
  logic [3:0] key_row [16] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111,
                               4'b1011, 4'b1011, 4'b1011, 4'b1101,
                               4'b1101, 4'b1101, 4'b0111, 4'b1011,
                               4'b1101, 4'b1110, 4'b1110, 4'b1110};
  logic [3:0] walk [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct {
    int         c;
    int         sig;
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   pd_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic done = 1'b0;
  logic [7:0] mon_got;
  int   mon_w;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] probe(input int sig);
    case (sig)
      0: return {4'h0, a_row};
      1: return {7'h0, a_ready};
      2: return {7'h0, a_busy};
      3: return {7'h0, a_pd};
      4: return a_hit;
      5: return {4'h0, b_row};
      6: return {7'h0, b_ready};
      7: return {7'h0, b_busy};
      8: return {7'h0, b_pd};
      default: return b_hit;
    endcase
  endfunction

  // Monitor: compares every expectation due this cycle, and checks each
  // press_done pulse of instance A against the expected pulse cycle.
  always @(negedge clock) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].c == cyc) begin
        n_vec++;
        mon_got = probe(exp_q[i].sig);
        if (mon_got !== exp_q[i].v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", exp_q[i].nm, cyc, mon_got, exp_q[i].v);
        end
        exp_q.delete(i);
      end
    end
    if (a_pd === 1'b1) begin
      n_vec++;
      if (pd_q.size() == 0) begin
        n_bad++;
        $display("FAIL pd_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        mon_w = pd_q.pop_front();
        if (mon_w != cyc) begin
          n_bad++;
          $display("FAIL pd_cycle got=%0d want=%0d", cyc, mon_w);
        end
      end
    end
    if (done) begin
      foreach (exp_q[i]) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s never_checked due=%0d", exp_q[i].nm, exp_q[i].c);
      end
      if (pd_q.size() != 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pd_missing got=%0d pending want=0", pd_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic ex(input int c, input int sig, input logic [7:0] v, input string nm);
    exp_q.push_back('{c, sig, v, nm});
  endtask

  task automatic accept(input bit on_b, input logic [3:0] k, output int e);
    int guard;
    guard = 0;
    while (((on_b ? b_ready : a_ready) !== 1'b1) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) begin
      $display("FAIL accept_wait key=%0h got=not_ready want=ready", k);
      $fatal(1, "accept wait expired");
    end
    if (on_b) begin b_key = k; b_valid = 1'b1; end
    else      begin a_key = k; a_valid = 1'b1; end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    e = cyc;
  endtask

  initial begin
    int e;
    logic [3:0] v;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_key = 4'h0;   b_key = 4'h0;
    a_col = 4'hF;   b_col = 4'hF;
    tick();
    tick();
    ex(cyc, 0, 8'h0F, "rst_a_row");  ex(cyc, 1, 8'd1, "rst_a_rdy");
    ex(cyc, 2, 8'd0, "rst_a_busy");  ex(cyc, 3, 8'd0, "rst_a_pd");
    ex(cyc, 4, 8'd0, "rst_a_hit");   ex(cyc, 5, 8'h0F, "rst_b_row");
    ex(cyc, 6, 8'd1, "rst_b_rdy");   ex(cyc, 9, 8'd0, "rst_b_hit");
    reset = 1'b0;
    tick();

    // Basic press of key 5 on its own column.
    a_col = 4'b1011;
    accept(1'b0, 4'h5, e);
    pd_q.push_back(e + 39);
    ex(e, 2, 8'd1, "t1_busy");          ex(e, 1, 8'd0, "t1_rdy_lo");
    ex(e, 0, 8'h0F, "t1_row_pre");      ex(e, 4, 8'd0, "t1_hit_clr");
    ex(e + 1, 0, 8'h0B, "t1_row_hold"); ex(e + 38, 3, 8'd0, "t1_pd_early");
    ex(e + 40, 0, 8'h0B, "t1_row_last"); ex(e + 41, 0, 8'h0F, "t1_row_gap");
    ex(e + 45, 4, 8'd1, "t1_hit");      ex(e + 49, 1, 8'd0, "t1_rdy_gap");
    ex(e + 50, 1, 8'd1, "t1_rdy_back"); ex(e + 50, 2, 8'd0, "t1_busy_off");
    run_to(e + 50);

    // Every key against a walking column scan.
    for (int k = 0; k < 16; k++) begin
      a_col = 4'hF;
      accept(1'b0, 4'(k), e);
      pd_q.push_back(e + 39);
      for (int s = 0; s < 12; s++) begin
        a_col = walk[s / 3];
        v = (a_col == key_col[k]) ? key_row[k] : 4'b1111;
        ex(e + s + 1, 0, {4'h0, v}, $sformatf("t2_row_k%0h_s%0d", k, s));
        tick();
      end
      a_col = 4'hF;
      run_to(e + 50);
    end

    // Key A with column toggling every 5 cycles: four rising edges in HOLD.
    accept(1'b0, 4'hA, e);
    pd_q.push_back(e + 39);
    ex(e, 4, 8'd0, "t4_hit0");
    ex(e + 1, 4, 8'd1, "t4_hit1");
    ex(e + 45, 4, 8'd4, "t4_hit_final");
    ex(e + 50, 4, 8'd4, "t4_hit_held");
    for (int s = 0; s < 40; s++) begin
      a_col = ((s / 5) % 2 == 0) ? 4'b1110 : 4'b1111;
      tick();
    end
    a_col = 4'hF;
    run_to(e + 50);

    // Key 7 held; key 3 offered mid-hold; illegal column drives.
    accept(1'b0, 4'h7, e);
    pd_q.push_back(e + 39);
    ex(e + 6, 1, 8'd0, "t5_rdy_busy");
    for (int s = 0; s < 30; s++) begin
      if (s < 10)      begin a_col = 4'b1101; v = 4'b1111; end
      else if (s < 15) begin a_col = 4'b0111; v = 4'b1101; end
      else if (s < 20) begin a_col = 4'b0011; v = 4'b1111; end
      else if (s < 25) begin a_col = 4'b0000; v = 4'b1111; end
      else             begin a_col = 4'b0111; v = 4'b1101; end
      ex(e + s + 1, 0, {4'h0, v}, $sformatf("t5_row_s%0d", s));
      if (s == 5) begin a_key = 4'h3; a_valid = 1'b1; end
      tick();
      a_valid = 1'b0;
    end
    a_col = 4'hF;
    ex(e + 50, 1, 8'd1, "t5_rdy_back");
    ex(e + 52, 2, 8'd0, "t5_no_queue");
    run_to(e + 52);

    // Reset in the middle of HOLD, then a fresh key.
    a_col = 4'b1110;
    accept(1'b0, 4'hC, e);
    ex(e + 5, 0, 8'h0D, "t6_row");
    ex(e + 5, 4, 8'd1, "t6_hit");
    run_to(e + 10);
    reset = 1'b1;
    tick();
    ex(cyc, 0, 8'h0F, "t6_rst_row"); ex(cyc, 1, 8'd1, "t6_rst_rdy");
    ex(cyc, 2, 8'd0, "t6_rst_busy"); ex(cyc, 4, 8'd0, "t6_rst_hit");
    reset = 1'b0;
    a_col = 4'b1101;
    accept(1'b0, 4'h9, e);
    pd_q.push_back(e + 39);
    ex(e, 2, 8'd1, "t6_k9_busy");   ex(e + 1, 0, 8'h0D, "t6_k9_row");
    ex(e + 20, 4, 8'd1, "t6_k9_hit"); ex(e + 50, 1, 8'd1, "t6_k9_rdy");
    run_to(e + 50);
    a_col = 4'hF;

    // Bounce: 4 pressed, 4 released, 4 pressed, then solid hold.
    b_col = 4'b0111;
    accept(1'b1, 4'h1, e);
    ex(e, 5, 8'h0F, "t3_row_pre");
    for (int s = 1; s <= 12; s++) begin
      v = (s <= 4 || s >= 9) ? 4'b0111 : 4'b1111;
      ex(e + s, 5, {4'h0, v}, $sformatf("t3_row_b%0d", s));
    end
    ex(e + 13, 5, 8'h07, "t3_row_hold");  ex(e + 1500, 5, 8'h07, "t3_row_mid");
    ex(e + 3012, 5, 8'h07, "t3_row_last"); ex(e + 3013, 5, 8'h0F, "t3_row_gap");
    ex(e + 12, 9, 8'd0, "t3_hit_bounce"); ex(e + 13, 9, 8'd1, "t3_hit1");
    ex(e + 3013, 9, 8'd1, "t3_hit_end");  ex(e + 3010, 8, 8'd0, "t3_pd_early");
    ex(e + 3011, 8, 8'd1, "t3_pd");       ex(e + 3013, 6, 8'd0, "t3_rdy_gap");
    ex(e + 3014, 6, 8'd1, "t3_rdy_back");
    run_to(e + 3014);

    // Saturation: 300 rising edges over a 3000-cycle hold.
    b_col = 4'hF;
    accept(1'b1, 4'hA, e);
    ex(e + 13, 9, 8'd1, "t7_hit1");     ex(e + 22, 9, 8'd1, "t7_hit1b");
    ex(e + 23, 9, 8'd2, "t7_hit2");     ex(e + 2552, 9, 8'd254, "t7_hit254");
    ex(e + 2553, 9, 8'd255, "t7_hit255"); ex(e + 2563, 9, 8'd255, "t7_sat");
    ex(e + 3013, 9, 8'd255, "t7_sat_end"); ex(e + 3014, 9, 8'd255, "t7_sat_held");
    run_to(e + 12);
    for (int s = 0; s < 3000; s++) begin
      b_col = ((s / 5) % 2 == 0) ? 4'b1110 : 4'b1111;
      tick();
    end
    b_col = 4'hF;
    run_to(e + 3014);

    tick();
    done = 1'b1;
  end

endmodule

// File: doc/pmod_keypad_emulator.md
Name: pmod_keypad_emulator

Overview:
- Behavioural-in-RTL model of the 4x4 Pmod keypad: the responder end of the column-scan/row-sense interface.
- Takes a key code over a valid/ready handshake and presses that key for a programmed time, optionally with contact bounce.
- Answers the scanner's active-low column drive with the matching active-low row pattern.
- Used for on-FPGA self-test and for simulation benches of the keypad scanner.

Parameters:
- CNT_W, 24, width of the internal phase timer.
- HOLD_CYCLES, 5000000, clean-press duration in clocks (must be ≥1).
- GAP_CYCLES, 1000000, released time after a press before the next key is accepted (may be 0).
- BOUNCE_CYCLES, 100000, bounce duration at press start (0 disables bounce).
- BOUNCE_PERIOD, 1000, clocks per bounce half-period (≥1).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- key_code, input, 4, key to press (0x0-0xF).
- key_valid, input, 1, key_code is valid.
- key_ready, output, 1, emulator idle and able to accept a key.
- Col, input, 4, column drive from the scanner, active-low one-hot.
- Row, output, 4, row sense to the scanner, active-low.
- busy, output, 1, a press/gap sequence is in progress.
- press_done, output, 1, one-cycle pulse at the end of HOLD.
- hit_count, output, 8, scans that hit the pressed key during HOLD (saturating).

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: state IDLE, Row=4'b1111, key_ready=1, busy=0, press_done=0, hit_count=0, timers=0. Reset mid-sequence aborts immediately; the next edge behaves as after power-up.
- Key map (column=Col value, row=Row value; C1..C4 = 0111,1011,1101,1110; R1..R4 likewise):
  - C1: R1=1, R2=4, R3=7, R4=0.
  - C2: R1=2, R2=5, R3=8, R4=F.
  - C3: R1=3, R2=6, R3=9, R4=E.
  - C4: R1=A, R2=B, R3=C, R4=D.
- Accept: key_valid&&key_ready in IDLE latches key_code, clears hit_count, and deasserts key_ready and asserts busy on the next cycle. key_valid outside IDLE is ignored (no queueing).
- States:
  - IDLE -> BOUNCE if BOUNCE_CYCLES>0, else -> HOLD.
  - BOUNCE lasts exactly BOUNCE_CYCLES clocks, then -> HOLD.
  - HOLD lasts exactly HOLD_CYCLES clocks, then -> GAP if GAP_CYCLES>0, else -> IDLE.
  - GAP lasts exactly GAP_CYCLES clocks, then -> IDLE.
- key_ready=1 and busy=0 exactly when in IDLE.
- pressed flag:
  - BOUNCE: starts 1 and toggles every BOUNCE_PERIOD clocks.
  - HOLD: 1.
  - IDLE/GAP: 0.
- Row is registered with 1-clock latency from Col:
  - Row = key's row pattern when pressed=1 and Col equals the key's column pattern exactly.
  - Otherwise Row = 4'b1111. This covers Col with zero lows, multiple lows, or another column.
- press_done: 1-cycle pulse on the HOLD exit cycle.
- hit_count: increments on each rising edge of the match condition (pressed && Col==key column) during HOLD only. Saturates at 255. Held after HOLD until the next accept.
- Col changing every cycle is legal; Row tracks it with 1-cycle latency.

Test Plan:
- Defaults overridden to HOLD=40, GAP=10, BOUNCE=0. Accept key 0x5; Col=1011 from cycle 2 -> Row=1011 one clock after HOLD entry; press_done at HOLD end; key_ready returns exactly 50 clocks after accept.
- All 16 codes, each with a walking Col (0111, 1011, 1101, 1110, 3 cycles each) -> Row matches the key map only on the matching column, else 1111. Cover 0x0→C1/R4, 0xF→C2/R4, 0xD→C4/R4.
- BOUNCE=12, PERIOD=4, key 0x1, Col=0111 held -> Row sequence 0111×4, 1111×4, 0111×4 in BOUNCE, then 0111 for all of HOLD; hit_count=1.
- Key 0xA, Col alternating 1110/1111 every 5 cycles through HOLD=40 -> hit_count=4. Repeat with HOLD=3000 and the same toggling -> hit_count saturates at 255.
- key_valid pulsed with 0x3 during HOLD of 0x7 -> ignored; Row never shows 0x3's pattern. Col=0011 (two lows) -> Row=1111.
- reset asserted mid-HOLD -> next cycle Row=1111, key_ready=1, busy=0, hit_count=0. A new key 0x9 is then accepted normally.
